// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO on the CPU data bus.
// Define UART_TX_PARITY_EN to add a parity bit (even/odd via CTRL bit2).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_7F20,
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        dm_w,
  input  logic        dm_r,
  input  logic [2:0]  dm_op,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        txd,
  output logic        irq
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = 16;
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [1:0]       offset;
  logic             wr_txdata, wr_status, wr_ctrl;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             empty, full, push, pop, can_pop;
  logic             ovf, en, ie, ie_nxt, par_odd, busy;
  logic [7:0]       data_q;
  logic             par_q;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]       bit_idx, idx_nxt, idx_inc;
  logic             bit_end, txd_nxt;
  logic             unused_bits;

  // Bus decode; byte offset and upper store data are don't-care
  assign offset    = addr[3:2];
  assign sel       = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
  assign wr_txdata = dm_w && sel && (offset == 2'd0);
  assign wr_status = dm_w && sel && (offset == 2'd1);
  assign wr_ctrl   = dm_w && sel && (offset == 2'd2);
  assign unused_bits = ^{dm_op, wdata[31:8], addr[1:0]};

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign push    = wr_txdata && !full;
  assign can_pop = en && !empty;
  assign busy    = (state != S_IDLE);
  assign bit_end = busy && (baud_cnt == '0);
  assign idx_inc = bit_idx + 3'd1;

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (pop && !push) count_nxt = count - CNT_W'(1);
  end

  // Control and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      en  <= 1'b0;
      ie  <= 1'b0;
    end else begin
      if (wr_txdata && full)          ovf <= 1'b1;
      else if (wr_status && wdata[3]) ovf <= 1'b0;
      if (wr_ctrl) begin
        en <= wdata[0];
        ie <= wdata[1];
      end
    end
  end

  assign ie_nxt = wr_ctrl ? wdata[1] : ie;

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          par_odd <= 1'b0;
    else if (wr_ctrl) par_odd <= wdata[2];
  end

  // Parity is fixed when the byte is loaded so a CTRL write cannot corrupt a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      par_q <= 1'b0;
    else if (pop) par_q <= (^mem[rd_ptr]) ^ par_odd;
  end
`else
  assign par_odd = 1'b0;
  assign par_q   = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (can_pop) state_nxt = S_START;
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA: begin
        if (bit_end && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_nxt = S_STOP;
`endif
      S_STOP:  if (bit_end) state_nxt = can_pop ? S_START : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: pop, bit timing and the next serial level
  always_comb begin
    pop      = 1'b0;
    baud_nxt = baud_cnt;
    idx_nxt  = bit_idx;
    txd_nxt  = txd;
    if (busy && !bit_end) baud_nxt = baud_cnt - BAUD_W'(1);
    case (state)
      S_IDLE: begin
        txd_nxt = 1'b1;
        if (can_pop) begin
          pop      = 1'b1;
          baud_nxt = BAUD_RELOAD;
          txd_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_nxt = BAUD_RELOAD;
          idx_nxt  = 3'd0;
          txd_nxt  = data_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_nxt = BAUD_RELOAD;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_nxt = par_q;
`else
            txd_nxt = 1'b1;
`endif
          end else begin
            idx_nxt = idx_inc;
            txd_nxt = data_q[idx_inc];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          baud_nxt = BAUD_RELOAD;
          txd_nxt  = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (can_pop) begin
            pop      = 1'b1;
            baud_nxt = BAUD_RELOAD;
            txd_nxt  = 1'b0;
          end else begin
            txd_nxt = 1'b1;
          end
        end
      end
      default: txd_nxt = 1'b1;
    endcase
  end

  // Transmit datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= 8'h00;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      txd      <= 1'b1;
      irq      <= 1'b0;
    end else begin
      if (pop) data_q <= mem[rd_ptr];
      baud_cnt <= baud_nxt;
      bit_idx  <= idx_nxt;
      txd      <= txd_nxt;
      irq      <= ie_nxt && (count_nxt == '0) && (state_nxt == S_IDLE);
    end
  end

  // Load data mux
  always_comb begin
    rdata = 32'h0;
    if (sel && dm_r) begin
      case (offset)
        2'd1:    rdata = {24'h0, 4'(count), ovf, empty, full, busy};
        2'd2:    rdata = {29'h0, par_odd, ie, en};
        default: rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized self-checking bench for mmio_uart_tx against a frame-level model.
// Honours UART_TX_PARITY_EN when the design is built with parity.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_7F20;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        dm_w, dm_r, sel, txd, irq;
  logic [2:0]  dm_op;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .dm_w(dm_w), .dm_r(dm_r),
    .dm_op(dm_op), .rdata(rdata), .sel(sel), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: byte queue plus current frame as a bit list and elapsed time
  logic [7:0] m_q[$];
  bit m_ovf, m_en, m_ie, m_par_odd, m_active;
  int m_t;
  bit m_bits[NB];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit exp_sel(input logic [31:0] a);
    return (a[31:4] == BASE[31:4]) && (a[3:2] != 2'b11);
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (exp_sel(a)) begin
      if (a[3:2] == 2'd1)
        v = {24'h0, 4'(m_q.size()), m_ovf, m_q.size() == 0, m_q.size() == DEPTH, m_active};
      else if (a[3:2] == 2'd2)
`ifdef UART_TX_PARITY_EN
        v = {29'h0, m_par_odd, m_ie, m_en};
`else
        v = {29'h0, 1'b0, m_ie, m_en};
`endif
    end
    return v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_en = 0; m_ie = 0; m_par_odd = 0; m_active = 0; m_t = 0;
  endtask

  task automatic start_frame(input logic [7:0] b);
    m_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) m_bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    m_bits[9] = (^b) ^ m_par_odd;
`endif
    m_bits[NB-1] = 1'b1;
    m_t = 0;
    m_active = 1;
  endtask

  // One clock edge: frame timing and pops use pre-edge state, then the bus write lands
  task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit full_pre;
    bit en_pre;
    full_pre = (m_q.size() == DEPTH);
    en_pre   = m_en;
    if (m_active) begin
      m_t++;
      if (m_t == NB * DIV) m_active = 0;
    end
    if (!m_active && en_pre && m_q.size() != 0) start_frame(m_q.pop_front());
    if (w && exp_sel(a)) begin
      case (a[3:2])
        2'd0: if (full_pre) m_ovf = 1; else m_q.push_back(d[7:0]);
        2'd1: if (d[3]) m_ovf = 0;
        2'd2: begin
          m_en = d[0];
          m_ie = d[1];
          m_par_odd = d[2];
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic exp_txd();
    return m_active ? m_bits[m_t / DIV] : 1'b1;
  endfunction

  task automatic bus_cycle(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; dm_w = w; dm_r = r; dm_op = 3'($urandom);
    #1;
    check_eq("sel", 32'(sel), 32'(exp_sel(a)));
    check_eq(r ? "rdata" : "rdata_idle", rdata, r ? exp_read(a) : 32'h0);
    @(posedge clk);
    model_step(w, a, d);
    #1;
    check_eq("txd", 32'(txd), 32'(exp_txd()));
    check_eq("irq", 32'(irq), 32'(m_ie && m_q.size() == 0 && !m_active));
    dm_w = 1'b0; dm_r = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, BASE + 32'(4 * (i % 4)), $urandom);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    bus_cycle(1'b1, 1'b0, BASE + 32'(off), d);
  endtask

  task automatic rd(input logic [3:0] off);
    bus_cycle(1'b0, 1'b1, BASE + 32'(off), $urandom);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) a = $urandom;
    else a = BASE + 32'($urandom_range(0, 15));
    return a;
  endfunction

  initial begin
    rst = 1'b1; addr = 32'h0; wdata = 32'h0; dm_w = 1'b0; dm_r = 1'b0; dm_op = 3'd0;
    model_reset();
    #1;
    check_eq("txd_in_reset", 32'(txd), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    rd(4'h4);
    rd(4'h8);
    rd(4'h0);

    // Single frame of 0xA5
    wr(4'h8, 32'h1);
    wr(4'h0, 32'hA5);
    idle(NB * DIV + 4);
    rd(4'h4);

    // Fill with transmitter disabled, overflow, then clear
    wr(4'h8, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      wr(4'h0, 32'(8'h11 * i));
      rd(4'h4);
    end
    wr(4'h4, 32'h8);
    rd(4'h4);

    // Drain four frames back to back with interrupt enabled
    wr(4'h8, 32'h3);
    idle(4 * NB * DIV + 6);

    // Push during the stop bit of the last frame
    wr(4'h0, 32'h5A);
    idle(NB * DIV - 3);
    wr(4'h0, 32'hC3);
    idle(NB * DIV + 6);

`ifdef UART_TX_PARITY_EN
    wr(4'h8, 32'h1);
    wr(4'h0, 32'h07);
    idle(NB * DIV + 2);
    wr(4'h8, 32'h5);
    wr(4'h0, 32'h07);
    idle(NB * DIV + 2);
`endif

    // Random bus traffic
    for (int i = 0; i < 2500; i++) begin
      int k;
      logic [31:0] a;
      logic [31:0] d;
      k = $urandom_range(0, 99);
      a = rand_addr();
      d = $urandom;
      if (k < 12) bus_cycle(1'b1, 1'b0, {a[31:4], 2'b00, a[1:0]}, d);
      else if (k < 15) bus_cycle(1'b1, 1'b0, {a[31:4], 2'b01, a[1:0]}, d);
      else if (k < 18) begin
        d[0] = ($urandom_range(0, 3) != 0);
        bus_cycle(1'b1, 1'b0, {a[31:4], 2'b10, a[1:0]}, d);
      end else if (k < 22) bus_cycle(1'b1, 1'b0, a, d);
      else if (k < 40) bus_cycle(1'b0, 1'b1, a, d);
      else bus_cycle(1'b0, 1'b0, a, d);
    end

    // Reset in the middle of a frame
    idle(4 * NB * DIV);
    wr(4'h8, 32'h1);
    wr(4'h0, 32'h3C);
    idle(10);
    rst = 1'b1;
    #1;
    check_eq("txd_async_rst", 32'(txd), 32'h1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd(4'h4);
    rd(4'h8);
    idle(NB * DIV);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
